// File: rtl/kb_pkg.sv
// Shared PS/2 scan-code constants, prefix-decoder state enum and make-key strobe bundle.
// Pure declarations: no latency or backpressure of its own.
package kb_pkg;

  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } kb_state_e;

  typedef struct packed {
    logic enter;
    logic esc;
    logic up;
    logic down;
    logic left;
    logic right;
  } kb_keys_t;

endpackage

// File: rtl/kb_prefix_decoder.sv
// PS/2 E0/F0 prefix tracker; make-key strobes are combinational in the scan_valid cycle.
// No backpressure: every qualified byte is consumed in the cycle it arrives.
module kb_prefix_decoder
  import kb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code_i,
  input  logic       scan_valid_i,
  output kb_keys_t   keys_o
);

  kb_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    keys_o  = '0;
    if (scan_valid_i) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code_i == SC_E0)      state_d = ST_GOT_E0;
          else if (scan_code_i == SC_F0) state_d = ST_GOT_F0;
          else begin
            keys_o.enter = (scan_code_i == SC_ENTER);
            keys_o.esc   = (scan_code_i == SC_ESC);
          end
        end
        ST_GOT_E0: begin
          // A repeated E0 keeps the extended prefix pending.
          if (scan_code_i == SC_F0)      state_d = ST_GOT_E0F0;
          else if (scan_code_i == SC_E0) state_d = ST_GOT_E0;
          else begin
            state_d      = ST_IDLE;
            keys_o.up    = (scan_code_i == SC_UP);
            keys_o.down  = (scan_code_i == SC_DOWN);
            keys_o.left  = (scan_code_i == SC_LEFT);
            keys_o.right = (scan_code_i == SC_RIGHT);
          end
        end
        default: state_d = ST_IDLE;  // break-code byte is dropped
      endcase
    end
  end

endmodule

// File: rtl/kb_field_editor.sv
// Keyboard-driven multi-field editor; key actions and loads land one cycle after their input.
// No backpressure. Optional Esc-cancel with snapshot restore under KB_FIELD_EDITOR_CANCEL_EN.
module kb_field_editor
  import kb_pkg::*;
#(
  parameter int NUM_FIELDS = 6,
  parameter int FIELD_W    = 7,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX =
    {7'd31, 7'd12, 7'd99, 7'd23, 7'd59, 7'd59}
)(
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_valid,
  input  logic                            ld_valid,
  input  logic [$clog2(NUM_FIELDS)-1:0]   ld_field,
  input  logic [FIELD_W-1:0]              ld_value,
  output logic [NUM_FIELDS*FIELD_W-1:0]   fields,
  output logic [$clog2(NUM_FIELDS)-1:0]   sel,
  output logic                            edit_active,
  output logic                            commit
);

  localparam int SEL_W = $clog2(NUM_FIELDS);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);

  typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] field_arr_t;
  localparam field_arr_t MAX_A = FIELD_MAX;

  kb_keys_t         keys;
  field_arr_t       fields_q, fields_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             edit_q, edit_d;
  logic             commit_q, commit_d;
  logic             ld_ok;

`ifdef KB_FIELD_EDITOR_CANCEL_EN
  field_arr_t snap_q, snap_d;
`else
  logic unused_esc;
  assign unused_esc = keys.esc;
`endif

  kb_prefix_decoder u_prefix (
    .clk          (clk),
    .reset        (reset),
    .scan_code_i  (scan_code),
    .scan_valid_i (scan_valid),
    .keys_o       (keys)
  );

  assign ld_ok = ld_valid && !edit_q && !keys.enter && (int'(ld_field) < NUM_FIELDS);

  always_comb begin
    fields_d = fields_q;
    sel_d    = sel_q;
    edit_d   = edit_q;
    commit_d = 1'b0;
`ifdef KB_FIELD_EDITOR_CANCEL_EN
    snap_d   = snap_q;
`endif
    if (keys.enter) begin
      if (edit_q) begin
        edit_d   = 1'b0;
        commit_d = 1'b1;
      end else begin
        edit_d   = 1'b1;
`ifdef KB_FIELD_EDITOR_CANCEL_EN
        snap_d   = fields_q;
`endif
      end
    end else if (edit_q) begin
      if (keys.up)
        fields_d[sel_q] = (fields_q[sel_q] >= MAX_A[sel_q]) ? '0
                                                              : fields_q[sel_q] + FIELD_W'(1);
      else if (keys.down)
        fields_d[sel_q] = (fields_q[sel_q] == '0) ? MAX_A[sel_q]
                                                  : fields_q[sel_q] - FIELD_W'(1);
      else if (keys.right)
        sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
      else if (keys.left)
        sel_d = (sel_q == '0) ? SEL_LAST : sel_q - SEL_W'(1);
`ifdef KB_FIELD_EDITOR_CANCEL_EN
      else if (keys.esc) begin
        fields_d = snap_q;
        edit_d   = 1'b0;
      end
`endif
    end else if (ld_ok) begin
      // Clamp keeps every stored field within its bound.
      fields_d[ld_field] = (ld_value > MAX_A[ld_field]) ? MAX_A[ld_field] : ld_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fields_q <= '0;
      sel_q    <= '0;
      edit_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      fields_q <= fields_d;
      sel_q    <= sel_d;
      edit_q   <= edit_d;
      commit_q <= commit_d;
    end
  end

`ifdef KB_FIELD_EDITOR_CANCEL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) snap_q <= '0;
    else        snap_q <= snap_d;
  end
`endif

  assign fields      = fields_q;
  assign sel         = sel_q;
  assign edit_active = edit_q;
  assign commit      = commit_q;

endmodule

// File: tb/tb_kb_field_editor.sv
// Scoreboard bench for kb_field_editor: directed scan/load vectors push expected outputs,
// a negedge monitor pops and compares. Esc expectations follow KB_FIELD_EDITOR_CANCEL_EN.
module tb_kb_field_editor;

  // Field 0 bounded at 31, field 1 at 12, so the day/month scenarios map onto fields 0 and 1.
  localparam logic [41:0] TB_MAX = {7'd59, 7'd59, 7'd23, 7'd99, 7'd12, 7'd31};

  logic        clk;
  logic        reset;
  logic [7:0]  scan_code;
  logic        scan_valid;
  logic        ld_valid;
  logic [2:0]  ld_field;
  logic [6:0]  ld_value;
  logic [41:0] fields;
  logic [2:0]  sel;
  logic        edit_active;
  logic        commit;

  typedef struct packed {
    logic [41:0] f;
    logic [2:0]  s;
    logic        e;
    logic        c;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  exp_t  mon_e;
  string mon_n;
  int    n_vec = 0;
  int    n_err = 0;

  kb_field_editor #(
    .NUM_FIELDS (6),
    .FIELD_W    (7),
    .FIELD_MAX  (TB_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_valid  (scan_valid),
    .ld_valid    (ld_valid),
    .ld_field    (ld_field),
    .ld_value    (ld_value),
    .fields      (fields),
    .sel         (sel),
    .edit_active (edit_active),
    .commit      (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [41:0] fv(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5);
    return {7'(a5), 7'(a4), 7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
  endtask

  task automatic arrow(input logic [7:0] b);
    send(8'hE0);
    send(b);
  endtask

  task automatic load(input int fld, input int val);
    ld_field = 3'(fld);
    ld_value = 7'(val);
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [41:0] f, input int s, input int e, input int c);
    exp_t x;
    x.f = f;
    x.s = 3'(s);
    x.e = 1'(e);
    x.c = 1'(c);
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      n_vec++;
      if (fields !== mon_e.f || sel !== mon_e.s || edit_active !== mon_e.e || commit !== mon_e.c) begin
        n_err++;
        $display("FAIL %s: got fields=%h sel=%0d edit=%0b commit=%0b, expected fields=%h sel=%0d edit=%0b commit=%0b",
                 mon_n, fields, sel, edit_active, commit, mon_e.f, mon_e.s, mon_e.e, mon_e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; scan_code = '0; scan_valid = 1'b0;
    ld_valid = 1'b0; ld_field = '0; ld_value = '0;
    tick(); tick();
    chk("reset", fv(0,0,0,0,0,0), 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();

    send(8'h5A);                 chk("enter_edit",   fv(0,0,0,0,0,0),   0, 1, 0);
    repeat (3) arrow(8'h75);     chk("up_x3",        fv(3,0,0,0,0,0),   0, 1, 0);
    arrow(8'h6B);                chk("left_wrap",    fv(3,0,0,0,0,0),   5, 1, 0);
    arrow(8'h74);                chk("right_wrap",   fv(3,0,0,0,0,0),   0, 1, 0);
    arrow(8'h74);                chk("right_inc",    fv(3,0,0,0,0,0),   1, 1, 0);
    arrow(8'h72);                chk("down_wrap_f1", fv(3,12,0,0,0,0),  1, 1, 0);
    arrow(8'h6B);                chk("left_dec",     fv(3,12,0,0,0,0),  0, 1, 0);
    repeat (4) arrow(8'h72);     chk("f0_to_max",    fv(31,12,0,0,0,0), 0, 1, 0);
    arrow(8'h75);                chk("up_wrap",      fv(0,12,0,0,0,0),  0, 1, 0);
    arrow(8'h72);                chk("down_wrap",    fv(31,12,0,0,0,0), 0, 1, 0);
    load(2, 5);                  chk("ld_in_edit",   fv(31,12,0,0,0,0), 0, 1, 0);

    send(8'hE0); send(8'hF0); send(8'h75);
                                 chk("brk_e0",       fv(31,12,0,0,0,0), 0, 1, 0);
    send(8'hF0); send(8'h5A);    chk("brk_enter",    fv(31,12,0,0,0,0), 0, 1, 0);
    send(8'h75);                 chk("bare_up",      fv(31,12,0,0,0,0), 0, 1, 0);

    send(8'h5A);                 chk("commit_hi",    fv(31,12,0,0,0,0), 0, 0, 1);
    tick();                      chk("commit_lo",    fv(31,12,0,0,0,0), 0, 0, 0);
    arrow(8'h75);                chk("arrow_idle",   fv(31,12,0,0,0,0), 0, 0, 0);

    load(1, 5);                  chk("ld_f1",        fv(31,5,0,0,0,0),  0, 0, 0);
    load(1, 100);                chk("ld_clamp",     fv(31,12,0,0,0,0), 0, 0, 0);
    load(3, 23);                 chk("ld_eq_max",    fv(31,12,0,23,0,0), 0, 0, 0);
    load(6, 1);                  chk("ld_oob6",      fv(31,12,0,23,0,0), 0, 0, 0);
    load(7, 1);                  chk("ld_oob7",      fv(31,12,0,23,0,0), 0, 0, 0);

    ld_field = 3'd4; ld_value = 7'd7; ld_valid = 1'b1;
    send(8'h5A);
    ld_valid = 1'b0;             chk("ld_enter",     fv(31,12,0,23,0,0), 0, 1, 0);
    arrow(8'h75);                chk("up_pre_esc",   fv(0,12,0,23,0,0),  0, 1, 0);
    send(8'h76);
`ifdef KB_FIELD_EDITOR_CANCEL_EN
                                 chk("esc_cancel",   fv(31,12,0,23,0,0), 0, 0, 0);
`else
                                 chk("esc_ignored",  fv(0,12,0,23,0,0),  0, 1, 0);
`endif

    send(8'hE0);
    reset = 1'b0;                chk("rst_mid",      fv(0,0,0,0,0,0),   0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    send(8'h5A);                 chk("post_rst_enter", fv(0,0,0,0,0,0), 0, 1, 0);
    arrow(8'h75);                chk("run2_up",      fv(1,0,0,0,0,0),   0, 1, 0);
    send(8'h5A);                 chk("run2_commit",  fv(1,0,0,0,0,0),   0, 0, 1);
    tick();                      chk("run2_commit_lo", fv(1,0,0,0,0,0), 0, 0, 0);

    tick(); tick();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kb_field_editor.md
KB_FIELD_EDITOR -- requirements
Module: kb_field_editor

Interface
REQ-001 SHALL have parameter NUM_FIELDS, default 6: number of editable fields (2..8).
REQ-002 SHALL have parameter FIELD_W, default 7: bit width of every field.
REQ-003 SHALL have parameter FIELD_MAX, default {7'd31,7'd12,7'd99,7'd23,7'd59,7'd59}: packed NUM_FIELDS*FIELD_W upper bounds; field i occupies bits [i*FIELD_W +: FIELD_W].
REQ-004 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port scan_code  input  8  PS/2 scan byte.
REQ-007 SHALL have port scan_valid  input  1  one-cycle strobe qualifying scan_code.
REQ-008 SHALL have port ld_valid  input  1  external load strobe.
REQ-009 SHALL have port ld_field  input  $clog2(NUM_FIELDS)  field index for the load.
REQ-010 SHALL have port ld_value  input  FIELD_W  value for the load.
REQ-011 SHALL have port fields  output  NUM_FIELDS*FIELD_W  all field values, packed as in FIELD_MAX.
REQ-012 SHALL have port sel  output  $clog2(NUM_FIELDS)  index of the selected field.
REQ-013 SHALL have port edit_active  output  1  high while in edit mode.
REQ-014 SHALL have port commit  output  1  one-cycle pulse when an edit is committed.

Function
REQ-015 SHALL decode bytes with a 4-state prefix FSM: IDLE, GOT_E0 (after 0xE0), GOT_F0 (after 0xF0), GOT_E0F0 (after E0 then F0).
REQ-016 SHALL treat any byte received in GOT_F0 or GOT_E0F0 as a break code, discard it, and return to IDLE.
REQ-017 SHALL act on make codes only: 0x5A Enter, 0x76 Esc; and E0-prefixed 0x75 Up, 0x72 Down, 0x6B Left, 0x74 Right. All other codes SHALL be ignored.
REQ-018 SHALL, on Enter while edit_active=0, set edit_active=1 on the next cycle.
REQ-019 SHALL, on Enter while edit_active=1, clear edit_active and pulse commit for exactly one cycle.
REQ-020 SHALL ignore arrow keys while edit_active=0.
REQ-021 SHALL, on Up, set the selected field to 0 if it equals FIELD_MAX[sel], and otherwise increment it by 1.
REQ-022 SHALL, on Down, set the selected field to FIELD_MAX[sel] if it equals 0, and otherwise decrement it by 1.
REQ-023 SHALL, on Right, advance sel by 1 and wrap from NUM_FIELDS-1 to 0.
REQ-024 SHALL, on Left, decrement sel by 1 and wrap from 0 to NUM_FIELDS-1.
REQ-025 SHALL make every key action visible on the outputs one cycle after the scan_valid cycle that carries it.
REQ-026 SHALL, on ld_valid with edit_active=0, write min(ld_value, FIELD_MAX[ld_field]) into field ld_field; an ld_field >= NUM_FIELDS SHALL be ignored.
REQ-027 SHALL ignore ld_valid while edit_active=1, and also in a cycle where an Enter make code is being processed.
REQ-028 SHALL never drive a field value above its FIELD_MAX.

Reset
REQ-029 SHALL, while reset=0, force all fields to 0, sel=0, edit_active=0, commit=0, and the FSM to IDLE, asynchronously.
REQ-030 SHALL discard any partial prefix sequence or edit in progress when reset is asserted, with no commit pulse.

Configuration
REQ-031 SHALL, when KB_FIELD_EDITOR_CANCEL_EN is defined, snapshot all fields on edit entry; Esc in edit mode SHALL then restore the snapshot and clear edit_active with no commit pulse.
REQ-032 SHALL, when KB_FIELD_EDITOR_CANCEL_EN is undefined, omit the snapshot registers and ignore Esc.

Structure
REQ-033 SHALL place the scan-code constants (Enter, Esc, Up, Down, Left, Right, 0xE0, 0xF0) and the FSM state enum in shared package kb_pkg.
REQ-034 SHALL implement the prefix FSM as sub-module kb_prefix_decoder, which emits one-cycle make-key strobes.

Verification
REQ-035 SHALL verify: after reset, send 5A, E0 75 x3 -> edit_active=1, field0=3, commit=0.
REQ-036 SHALL verify: with field0=31, send E0 75 -> field0=0; then send E0 72 -> field0=31.
REQ-037 SHALL verify: with sel=0 in edit mode, send E0 6B -> sel=5; then send E0 74 -> sel=0.
REQ-038 SHALL verify: send E0 F0 75 and F0 5A -> no field, sel, or mode change.
REQ-039 SHALL verify: with the macro defined, send 5A, E0 75, 76 -> fields equal their pre-edit values, commit=0; in a second run send 5A, E0 75, 5A -> field0=1 and commit high for exactly one cycle.
REQ-040 SHALL verify: ld_valid with ld_field=1, ld_value=100 while idle -> field1=12; a load while edit_active=1 -> fields unchanged; reset asserted mid-sequence after E0 -> all outputs 0.
